// File: rtl/mem_arb_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and helpers for the memory arbiter        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_ARB  = 1'b1
    } arb_state_e;

    // Index width for a requester count, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// +----------------------------------------------------------------------+
// | mem_arbiter_if : requester-side request/response bundle              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_we;
    logic [NUM_REQ*AW-1:0]    req_addr;
    logic [NUM_REQ*WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin grant from a rotating pointer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    always_comb begin
        int         w_cand;
        logic [IW-1:0] w_sel;
        logic       w_found;
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        w_sel     = '0;
        // Scan upward from the pointer, wrapping modulo NUM_REQ.
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = (int'(ptr) + i) % NUM_REQ;
            w_sel  = IW'(w_cand);
            if (!w_found && req[w_sel]) begin
                w_found      = 1'b1;
                grant[w_sel] = 1'b1;
                grant_idx    = w_sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_arbiter : round-robin sharing of one single-port memory          |
// | Optional zero-fill after reset when MEM_ARB_INIT_EN is defined.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_arbiter_if.slave     bus,
    output logic             init_done,
    output logic             mem_write_en,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_data_in,
    input  logic [WIDTH-1:0] mem_data_out
);

    localparam int c_IW = idx_width(NUM_REQ);

    logic               w_arb_en;
    logic               w_any;
    logic               w_gwe;
    logic               w_init_we;
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [c_IW-1:0]    w_gidx;
    logic [c_IW-1:0]    r_rr_ptr;
    logic [AW-1:0]      w_gaddr;
    logic [AW-1:0]      r_last_addr;
    logic [AW-1:0]      w_init_addr;
    logic [WIDTH-1:0]   w_gwdata;
    logic [WIDTH-1:0]   r_last_wdata;

    assign w_req = bus.req_valid & {NUM_REQ{w_arb_en}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (c_IW)
    ) u_rr (
        .req       (w_req),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx)
    );

    assign w_any    = |w_grant;
    assign w_gwe    = bus.req_we[w_gidx];
    assign w_gaddr  = bus.req_addr[int'(w_gidx)*AW +: AW];
    assign w_gwdata = bus.req_wdata[int'(w_gidx)*WIDTH +: WIDTH];

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_valid;
    // Memory output is only meaningful while a response is being presented.
    assign bus.rsp_rdata = (|r_rsp_valid) ? mem_data_out : '0;
    assign init_done     = w_arb_en;

`ifdef MEM_ARB_INIT_EN
    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic [AW-1:0] r_init_cnt;
    logic          r_started;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_started  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_started <= 1'b1;
            if (w_init_we) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    // Fill starts one edge after reset so the memory sees no write during reset.
    always_comb begin
        w_state_nxt = r_state;
        w_init_we   = 1'b0;
        case (r_state)
            S_INIT: begin
                if (r_started) begin
                    w_init_we = 1'b1;
                    if (r_init_cnt == AW'(DEPTH-1)) begin
                        w_state_nxt = S_ARB;
                    end
                end
            end
            S_ARB:   w_state_nxt = S_ARB;
        endcase
    end

    assign w_arb_en    = (r_state == S_ARB);
    assign w_init_addr = r_init_cnt;
`else
    logic r_init_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b1;
        end
    end

    assign w_arb_en    = r_init_done;
    assign w_init_we   = 1'b0;
    assign w_init_addr = '0;
`endif

    always_comb begin
        mem_write_en = w_any & w_gwe;
        mem_addr     = w_any ? w_gaddr  : r_last_addr;
        mem_data_in  = w_any ? w_gwdata : r_last_wdata;
        if (w_init_we) begin
            mem_write_en = 1'b1;
            mem_addr     = w_init_addr;
            mem_data_in  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_rsp_valid  <= '0;
            r_last_addr  <= '0;
            r_last_wdata <= '0;
        end else begin
            if (w_any) begin
                r_rr_ptr     <= (w_gidx == c_IW'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;
                r_last_addr  <= w_gaddr;
                r_last_wdata <= w_gwdata;
            end
            r_rsp_valid <= (w_any && !w_gwe) ? w_grant : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : directed scoreboard bench for mem_arbiter           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DEPTH   = 16;
    localparam int WIDTH   = 8;
    localparam int AW      = 4;
`ifdef MEM_ARB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .WIDTH(WIDTH)) bus ();

    logic             init_done;
    logic             mem_write_en;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_data_in;
    logic [WIDTH-1:0] mem_data_out;
    logic [WIDTH-1:0] mem_model [DEPTH];

    // Single-port memory: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_write_en) mem_model[mem_addr] <= mem_data_in;
        mem_data_out <= mem_model[mem_addr];
    end

    mem_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .init_done    (init_done),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    typedef struct packed {
        logic [1:0] vld;
        logic [7:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid !== 2'b00) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {30'd0, bus.rsp_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, mon_e.vld});
                check("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, mon_e.data});
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {d1, d0};
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [3:0] a0, input logic [3:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] exp_rdy, input logic [7:0] exp_data);
        logic g;
        drive(v, we, a0, a1, d0, d1);
        @(negedge clk);
        check("req_ready", {30'd0, bus.req_ready}, {30'd0, exp_rdy});
        if (exp_rdy != 2'b00) begin
            g = exp_rdy[1];
            check("mem_write_en", {31'd0, mem_write_en}, {31'd0, we[g]});
            check("mem_addr", {28'd0, mem_addr}, {28'd0, (g ? a1 : a0)});
            if (we[g]) check("mem_data_in", {24'd0, mem_data_in}, {24'd0, (g ? d1 : d0)});
            else       exp_q.push_back({exp_rdy, exp_data});
        end else begin
            check("mem_write_en_idle", {31'd0, mem_write_en}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks();
        check("rst_req_ready",   {30'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid",   {30'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata",   {24'd0, bus.rsp_rdata}, 32'd0);
        check("rst_init_done",   {31'd0, init_done},     32'd0);
        check("rst_mem_we",      {31'd0, mem_write_en},  32'd0);
        check("rst_mem_addr",    {28'd0, mem_addr},      32'd0);
        check("rst_mem_data_in", {24'd0, mem_data_in},   32'd0);
    endtask

    // Waits for init_done; with_req holds both requesters reading addr 0 / 9.
    task automatic wait_init(input bit with_req, input logic [7:0] exp_data);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (init_done === 1'b1) begin
                done = 1'b1;
                check("init_latency", n, INIT_EN ? DEPTH + 2 : 2);
                if (with_req) begin
                    check("first_grant", {30'd0, bus.req_ready}, 32'd1);
                    exp_q.push_back({2'b01, exp_data});
                end
            end else begin
                check("ready_before_init", {30'd0, bus.req_ready}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("init_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
        @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init(1'b0, 8'h00);

        // Write then read back through requester 0.
        step(2'b01, 2'b01, 4'd3, 4'd0, 8'h5A, 8'h00, 2'b01, 8'h00);
        step(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00, 2'b01, 8'h5A);
        step(2'b10, 2'b10, 4'd0, 4'd0, 8'h00, 8'h77, 2'b10, 8'h00);
        step(2'b01, 2'b01, 4'd5, 4'd0, 8'h11, 8'h00, 2'b01, 8'h00);
        step(2'b10, 2'b10, 4'd0, 4'd6, 8'h00, 8'h22, 2'b10, 8'h00);

        // Continuous contention alternates 0,1,0,1,...
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 2'b00, 4'd5, 4'd6, 8'h00, 8'h00,
                 (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 8'h11 : 8'h22);
        end

        // Requester 1 alone with pointer 0; pointer wraps back to 0.
        step(2'b10, 2'b00, 4'd0, 4'd6, 8'h00, 8'h00, 2'b10, 8'h22);
        step(2'b11, 2'b00, 4'd5, 4'd6, 8'hA5, 8'h00, 2'b01, 8'h11);

        // Idle: memory address/data hold the last granted values.
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        @(negedge clk);
        check("idle_ready",  {30'd0, bus.req_ready}, 32'd0);
        check("idle_we",     {31'd0, mem_write_en},  32'd0);
        check("idle_addr",   {28'd0, mem_addr},      32'd5);
        check("idle_wdata",  {24'd0, mem_data_in},   32'hA5);
        @(posedge clk);
        #1;

        // Read immediately after write to the same address.
        step(2'b10, 2'b10, 4'd0, 4'd9, 8'h00, 8'hC3, 2'b10, 8'h00);
        step(2'b10, 2'b00, 4'd0, 4'd9, 8'h00, 8'h00, 2'b10, 8'hC3);

        // Read grant, then reset in the response cycle.
        step(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00, 2'b01, 8'h5A);
        rst_n = 1'b0;
        exp_q.delete();
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        #1;
        reset_checks();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(2'b11, 2'b00, 4'd0, 4'd9, 8'h00, 8'h00);
        wait_init(1'b1, INIT_EN ? 8'h00 : 8'h77);
        step(2'b11, 2'b00, 4'd0, 4'd9, 8'h00, 8'h00, 2'b10, INIT_EN ? 8'h00 : 8'hC3);

`ifdef MEM_ARB_INIT_EN
        for (int a = 0; a < DEPTH; a++) begin
            step(2'b01, 2'b00, 4'(a), 4'd0, 8'h00, 8'h00, 2'b01, 8'h00);
        end
`endif

        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing one single-port `memory` instance (DEPTH x WIDTH, synchronous write, registered read) between NUM_REQ requesters. Each requester issues reads or writes over a valid/ready handshake. Read data returns on a per-requester response channel. The arbiter sits directly in front of `memory` and owns all of its control inputs. An optional post-reset sequencer zero-fills the array before any requester is served.

## Interface
- NUM_REQ, 2: number of requesters (2..8).
- DEPTH, 16: memory depth; address width AW = $clog2(DEPTH).
- WIDTH, 8: data width.
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*AW  packed addresses; requester i is at [i*AW +: AW].
- req_wdata  in  NUM_REQ*WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid & ready.
- rsp_valid  out  NUM_REQ  one-hot read-response strobe.
- rsp_rdata  out  WIDTH  read data, qualified by rsp_valid.
- init_done  out  1  high once the arbiter accepts requests.
- mem_write_en  out  1  to memory write_en.
- mem_addr  out  AW  to memory addr.
- mem_data_in  out  WIDTH  to memory data_in.
- mem_data_out  in  WIDTH  from memory data_out; valid one cycle after the address is sampled.

## Operation
- States: S_INIT (zero-fill, only present with the macro) and S_ARB.
- In S_ARB, grant goes to the first valid requester at or after the round-robin pointer `rr_ptr`, searching upward modulo NUM_REQ.
- `req_ready` is combinational from `req_valid` and `rr_ptr`. At most one bit is set. It is 0 when no requester is valid.
- The memory ports are driven combinationally from the granted requester:
  - mem_write_en = granted & req_we;
  - mem_addr and mem_data_in come from the granted requester.
- With no grant, mem_write_en = 0, and mem_addr and mem_data_in hold the last granted values.
- On each grant to requester g, `rr_ptr` becomes (g+1) mod NUM_REQ on the next edge. With no grant, `rr_ptr` holds.
- Read granted in cycle t: rsp_valid[g] = 1 in cycle t+1, and rsp_rdata = mem_data_out in that cycle.
- Writes produce no response.
- Requester fairness: with all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
- Back-to-back transactions are allowed; throughput is 1 access per cycle.
- A read issued the cycle after a write to the same address returns the new data, because the memory write completes at the grant edge.

## Timing
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, init_done = 0;
  - mem_write_en = 0, mem_addr = 0, mem_data_in = 0;
  - rr_ptr = 0.
- Reset asserted mid-operation: a pending read response is dropped (rsp_valid = 0 immediately), and the state returns to S_INIT or S_ARB per the configuration.
- Grant-to-memory latency is 0 cycles. Read latency is 1 cycle from handshake to rsp_valid.
- A requester must hold valid, we, addr and wdata stable until ready. The arbiter never withdraws ready in a cycle in which the request stays valid.

## Configuration
- MEM_ARB_INIT_EN defined:
  - After reset, the FSM is in S_INIT. Counter `init_cnt` runs 0..DEPTH-1, one write per cycle: mem_write_en = 1, mem_addr = init_cnt, mem_data_in = 0.
  - req_ready = 0 throughout S_INIT.
  - After the DEPTH-1 write, the FSM moves to S_ARB and init_done = 1 from the next cycle.
  - The first grant is possible DEPTH+1 cycles after reset deassertion.
- MEM_ARB_INIT_EN undefined: there is no S_INIT and no counter. init_done rises at the first posedge after reset deassertion, and grants are possible from that cycle.

## Structure
- Package `mem_arb_pkg` holds:
  - typedef enum logic [0:0] {S_INIT, S_ARB} arb_state_e;
  - the helper function for the index width, $clog2(NUM_REQ) with a minimum of 1.
- Sub-module `rr_arbiter`: purely combinational grant logic. Inputs are req and ptr; outputs are the one-hot grant and the encoded grant index.
- `mem_arbiter` instantiates `rr_arbiter` and contains the FSM, the pointer, and the response pipeline.

## Test plan
- Single requester 0 writes addr 3 = 0x5A, then reads addr 3 → req_ready[0] on both cycles; rsp_valid[0] one cycle after the read with rsp_rdata = 0x5A.
- Both requesters valid continuously with reads for 6 cycles → grants alternate 0,1,0,1,0,1, and each rsp_valid follows its grant by 1 cycle.
- Requester 1 only, pointer at 0 → granted immediately; rr_ptr becomes 0 (wraps).
- With MEM_ARB_INIT_EN: pre-load nonzero, reset, then read all DEPTH addresses → all return 0; init_done rises at cycle DEPTH+1; no req_ready before it.
- Reset asserted the cycle after a read grant → rsp_valid stays 0, all outputs return to reset values, and the FSM restarts.
